// File: rtl/lb_pkg.sv
// Shared constants for the local write bus shadow register bank.
// Bus widths, window size and control-register layout.
package lb_pkg;
    localparam int          LB_DW          = 32;
    localparam int          LB_AW          = 16;
    localparam int          LB_WIN_BITS    = 4;
    localparam int          LB_NREG        = 1 << LB_WIN_BITS;
    localparam logic [3:0]  LB_CTRL        = 4'd0;
    localparam int          LB_CTRL_COMMIT = 0;
endpackage

// File: rtl/lb_shadow_regs_sat_counter.sv
// Saturating event counter; a clear that coincides with an event
// loads 1 so the event is not lost.
module sat_counter #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [width-1:0] cnt
);
    logic [width-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= inc ? width'(1) : '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + width'(1);
        end
    end

    assign cnt = r_cnt;
endmodule

// File: rtl/lb_shadow_regs.sv
// Local-bus register endpoint: shadow registers committed to the
// active set on apply, plus collision tracking and readback.
module lb_shadow_regs
    import lb_pkg::*;
#(
    parameter int addr_hi = 1,
    parameter int cnt_w   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LB_DW-1:0]        lb_data,
    input  logic                    lb_write,
    input  logic [LB_AW-1:0]        lb_addr,
    input  logic                    collision,
    input  logic                    apply,
    input  logic                    clear_cnt,
    input  logic [LB_WIN_BITS-1:0]  rd_addr,
    input  logic                    rd_shadow,
    output logic [LB_DW-1:0]        rd_data,
    output logic [LB_NREG*LB_DW-1:0] reg_flat,
    output logic                    update_stb,
    output logic                    pending,
    output logic                    collision_seen,
    output logic [cnt_w-1:0]        write_cnt,
    output logic [cnt_w-1:0]        collision_cnt
);
    logic [LB_DW-1:0]   r_shadow [LB_NREG];
    logic [LB_DW-1:0]   r_active [LB_NREG];
    logic [LB_NREG-1:0] r_dirty;
    logic               r_pending;
    logic               r_update_stb;
    logic               r_seen;
    logic [LB_DW-1:0]   r_rd_data;

    logic                   w_local;
    logic [LB_WIN_BITS-1:0] w_off;
    logic                   w_wr_data;
    logic                   w_force;
    logic                   w_commit;
    logic [LB_NREG-1:0]     w_dirty_nxt;
    logic [LB_DW-1:0]       w_rd_nxt;

    assign w_off     = lb_addr[LB_WIN_BITS-1:0];
    assign w_local   = lb_write &&
                       (lb_addr[LB_AW-1:LB_WIN_BITS] ==
                        (LB_AW-LB_WIN_BITS)'(addr_hi));
    assign w_wr_data = w_local && (w_off != LB_CTRL);
    assign w_force   = w_local && (w_off == LB_CTRL) &&
                       lb_data[LB_CTRL_COMMIT];
    assign w_commit  = (apply || w_force) && r_pending;

    // A write landing with a commit survives as the only dirty bit.
    always_comb begin
        w_dirty_nxt = w_commit ? '0 : r_dirty;
        if (w_wr_data) begin
            w_dirty_nxt[w_off] = 1'b1;
        end
    end

    always_comb begin
        w_rd_nxt = '0;
        if (rd_addr == LB_CTRL) begin
            w_rd_nxt = {16'(collision_cnt), 16'(write_cnt)};
        end else if (rd_shadow) begin
            w_rd_nxt = r_shadow[rd_addr];
        end else begin
            w_rd_nxt = r_active[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LB_NREG; k++) begin
                r_shadow[k] <= '0;
                r_active[k] <= '0;
            end
            r_dirty      <= '0;
            r_pending    <= 1'b0;
            r_update_stb <= 1'b0;
            r_seen       <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            for (int k = 1; k < LB_NREG; k++) begin
                if (w_commit && r_dirty[k]) begin
                    r_active[k] <= r_shadow[k];
                end
            end
            if (w_wr_data) begin
                r_shadow[w_off] <= lb_data;
            end
            r_dirty      <= w_dirty_nxt;
            r_pending    <= |w_dirty_nxt;
            r_update_stb <= w_commit;
            r_seen       <= clear_cnt ? collision : (r_seen | collision);
            r_rd_data    <= w_rd_nxt;
        end
    end

    sat_counter #(.width(cnt_w)) u_write_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_local),
        .clr   (clear_cnt),
        .cnt   (write_cnt)
    );

    sat_counter #(.width(cnt_w)) u_coll_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (collision),
        .clr   (clear_cnt),
        .cnt   (collision_cnt)
    );

    assign reg_flat[LB_DW-1:0] = '0;
    for (genvar g = 1; g < LB_NREG; g++) begin : g_flat
        assign reg_flat[g*LB_DW +: LB_DW] = r_active[g];
    end

    assign rd_data        = r_rd_data;
    assign update_stb     = r_update_stb;
    assign pending        = r_pending;
    assign collision_seen = r_seen;
endmodule

// File: tb/tb_lb_shadow_regs.sv
// Scoreboard bench for lb_shadow_regs against a behavioural model.
module tb_lb_shadow_regs;
    import lb_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [31:0]  lb_data = '0;
    logic         lb_write = 1'b0;
    logic [15:0]  lb_addr = '0;
    logic         collision = 1'b0;
    logic         apply = 1'b0;
    logic         clear_cnt = 1'b0;
    logic [3:0]   rd_addr = '0;
    logic         rd_shadow = 1'b0;
    logic [31:0]  rd_data;
    logic [511:0] reg_flat;
    logic         update_stb;
    logic         pending;
    logic         collision_seen;
    logic [15:0]  write_cnt;
    logic [15:0]  collision_cnt;

    lb_shadow_regs #(.addr_hi(1), .cnt_w(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lb_data        (lb_data),
        .lb_write       (lb_write),
        .lb_addr        (lb_addr),
        .collision      (collision),
        .apply          (apply),
        .clear_cnt      (clear_cnt),
        .rd_addr        (rd_addr),
        .rd_shadow      (rd_shadow),
        .rd_data        (rd_data),
        .reg_flat       (reg_flat),
        .update_stb     (update_stb),
        .pending        (pending),
        .collision_seen (collision_seen),
        .write_cnt      (write_cnt),
        .collision_cnt  (collision_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  rd;
        logic [511:0] flat;
        logic         stb;
        logic         pend;
        logic         seen;
        logic [15:0]  wc;
        logic [15:0]  cc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    logic [31:0] m_sh  [16];
    logic [31:0] m_act [16];
    bit          m_dirty [16];
    int          m_wc, m_cc;
    bit          m_seen;

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 16; k++) begin
            m_sh[k] = '0;
            m_act[k] = '0;
            m_dirty[k] = 0;
        end
        m_wc = 0;
        m_cc = 0;
        m_seen = 0;
    endfunction

    function automatic bit any_dirty();
        for (int k = 0; k < 16; k++) if (m_dirty[k]) return 1;
        return 0;
    endfunction

    task automatic step(input bit wr, input logic [15:0] a,
                        input logic [31:0] d, input bit col,
                        input bit ap, input bit clr,
                        input logic [3:0] rda, input bit rds);
        exp_t e;
        bit   loc;
        int   off;
        bit   cmt;
        @(negedge clk);
        lb_write = wr; lb_addr = a; lb_data = d; collision = col;
        apply = ap; clear_cnt = clr; rd_addr = rda; rd_shadow = rds;
        loc = wr && (a[15:4] == 12'h001);
        off = int'(a[3:0]);
        if (rda == 0) e.rd = {m_cc[15:0], m_wc[15:0]};
        else e.rd = rds ? m_sh[rda] : m_act[rda];
        cmt = (ap || (loc && off == 0 && d[0])) && any_dirty();
        if (cmt) begin
            for (int k = 1; k < 16; k++) begin
                if (m_dirty[k]) m_act[k] = m_sh[k];
                m_dirty[k] = 0;
            end
        end
        if (loc && off != 0) begin
            m_sh[off] = d;
            m_dirty[off] = 1;
        end
        if (clr) m_wc = loc ? 1 : 0;
        else if (loc && m_wc < 65535) m_wc++;
        if (clr) m_cc = col ? 1 : 0;
        else if (col && m_cc < 65535) m_cc++;
        m_seen = clr ? col : (m_seen | col);
        e.stb = cmt;
        e.pend = any_dirty();
        e.seen = m_seen;
        e.wc = m_wc[15:0];
        e.cc = m_cc[15:0];
        e.flat = '0;
        for (int k = 1; k < 16; k++) e.flat[k*32 +: 32] = m_act[k];
        q.push_back(e);
    endtask

    task automatic idle(input logic [3:0] rda, input bit rds);
        step(0, 16'h0, 32'h0, 0, 0, 0, rda, rds);
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d,
                      input bit ap);
        step(1, a, d, 0, ap, 0, 4'd0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("rd_data", 512'(rd_data), 512'(e.rd));
                chk("reg_flat", reg_flat, e.flat);
                chk("update_stb", 512'(update_stb), 512'(e.stb));
                chk("pending", 512'(pending), 512'(e.pend));
                chk("collision_seen", 512'(collision_seen), 512'(e.seen));
                chk("write_cnt", 512'(write_cnt), 512'(e.wc));
                chk("collision_cnt", 512'(collision_cnt), 512'(e.cc));
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd"}, 512'(rd_data), 512'(0));
        chk({tag, "_flat"}, reg_flat, 512'(0));
        chk({tag, "_ctl"},
            512'({update_stb, pending, collision_seen}), 512'(0));
        chk({tag, "_cnt"}, 512'({write_cnt, collision_cnt}), 512'(0));
    endtask

    initial begin : driver
        model_reset();
        #2 rst_n = 1'b0;
        #3 chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // write offset 3, read back shadow then active
        wr(16'h0013, 32'h12345678, 0);
        idle(4'd3, 1);
        idle(4'd3, 0);
        idle(4'd0, 0);
        // commit, then a commit with nothing pending
        step(0, 16'h0, 32'h0, 0, 1, 0, 4'd3, 0);
        idle(4'd3, 0);
        step(0, 16'h0, 32'h0, 0, 1, 0, 4'd0, 0);
        idle(4'd0, 0);
        // write colliding with commit
        wr(16'h0013, 32'h1, 0);
        wr(16'h0015, 32'hA, 1);
        idle(4'd5, 1);
        step(0, 16'h0, 32'h0, 0, 1, 0, 4'd5, 0);
        idle(4'd5, 0);
        // forced commit via control register, then non-local write
        wr(16'h0017, 32'hCAFE, 0);
        wr(16'h0010, 32'h1, 0);
        wr(16'h0023, 32'hDEAD, 0);
        idle(4'd7, 0);
        idle(4'd0, 0);
        // control write without commit bit
        wr(16'h0019, 32'h5, 0);
        wr(16'h0010, 32'h2, 0);
        idle(4'd9, 0);
        // collision saturation and clear-with-event
        for (int i = 0; i < 32'hFFFF + 2; i++)
            step(0, 16'h0, 32'h0, 1, 0, 0, 4'd0, 0);
        idle(4'd0, 0);
        step(0, 16'h0, 32'h0, 1, 0, 1, 4'd0, 0);
        idle(4'd0, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] a;
            int r;
            r = $urandom_range(0, 9);
            if (r < 8) a = {12'h001, 4'($urandom_range(0, 15))};
            else if (r == 8) a = 16'h0023;
            else a = 16'($urandom);
            step($urandom_range(0, 1) == 1, a, $urandom,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 30) == 0,
                 4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
        end
        // async reset with pending writes
        wr(16'h0012, 32'h1111, 0);
        wr(16'h0014, 32'h2222, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        lb_write = 0; apply = 0; collision = 0; clear_cnt = 0;
        rst_n = 1'b1;
        idle(4'd0, 0);
        step(0, 16'h0, 32'h0, 0, 1, 0, 4'd2, 1);
        idle(4'd4, 0);
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lb_shadow_regs.md
# lb_shadow_regs

Register-bank endpoint for the 32-bit local write bus, sitting downstream of a function-generator or other bus interposer. It decodes writes into a 16-address window and holds them in shadow registers. It commits dirty shadows to the active register set on an external `apply` strobe, so parameter changes land on a pulse boundary. It also latches and counts the single-cycle `collision` pulses that the upstream interposer emits, and provides a one-cycle readback port.

## Interface
- `addr_hi`, default 1: window base is 16*`addr_hi`; a write is local when `lb_addr[15:4]==addr_hi`.
- `cnt_w`, default 16: width of the write and collision counters.
- `clk` input 1: single clock; everything is on posedge.
- `rst_n` input 1: reset, asynchronous assert, active-low; deassertion is synchronized upstream.
- `lb_data` input 32: bus write data.
- `lb_write` input 1: bus write strobe, single cycle.
- `lb_addr` input 16: bus write address.
- `collision` input 1: single-cycle lost-write pulse from the interposer.
- `apply` input 1: commit strobe.
- `clear_cnt` input 1: zeroes both counters.
- `rd_addr` input 4: readback offset.
- `rd_shadow` input 1: 1 reads the shadow register, 0 reads the active register.
- `rd_data` output 32: readback data, registered.
- `reg_flat` output 512: active registers 0..15; offset k occupies bits [32k+31:32k].
- `update_stb` output 1: one-cycle pulse when a commit occurred.
- `pending` output 1: at least one shadow is dirty.
- `collision_seen` output 1: sticky; set by `collision`, cleared by `clear_cnt`.
- `write_cnt` output `cnt_w`: count of local writes, saturating.
- `collision_cnt` output `cnt_w`: count of collisions, saturating.

## Operation
- Local write to offset k, k in 1..15: `shadow[k]` is loaded with `lb_data` and `dirty[k]` is set.
- Offset 0 is the control register. A write with `lb_data[0]=1` forces a commit exactly as `apply` does. Other bits are ignored. Offset 0 never holds data.
- Commit happens when `apply` or a forced commit occurs while `pending=1`:
  - `active[k]` is loaded with `shadow[k]` for every dirty k.
  - `dirty` is cleared.
  - `update_stb` pulses.
- A commit with `pending=0` is a no-op: there is no `update_stb`.
- Write and commit in the same cycle: the commit uses the pre-edge shadow values. The new write lands in the shadow and its dirty bit stays set, so `pending` remains 1.
- Non-local writes are ignored.
- `write_cnt` increments on every local write, including writes to offset 0.
- `collision_cnt` increments on `collision`.
- Both counters saturate at all-ones.
- `clear_cnt` with a coincident event loads 1 into the affected counter, so the event is not lost.
- Readback:
  - `rd_addr=0` returns {`collision_cnt`[15:0], `write_cnt`[15:0]}, zero-extended or truncated to 16 bits each.
  - Otherwise `rd_data` returns the shadow or active register selected by `rd_shadow`.
- `active[0]` always reads as 0 in `reg_flat`.

## Timing
- Reset, asynchronous on `rst_n` low, clears to 0: all shadow, active and dirty state, `pending`, `update_stb`, `collision_seen`, both counters, and `rd_data`.
- `rst_n` low mid-commit: the commit is abandoned and everything reads 0 afterwards.
- Write sampled at edge N: the shadow is valid after N, and `pending` is 1 in cycle N+1.
- `apply` sampled at edge A: `reg_flat` changes after A, and `update_stb` is high for exactly the cycle after A.
- Readback latency is 1: `rd_addr` sampled at edge R gives `rd_data` valid after R.
- `pending` is registered and equals OR(`dirty`) as of the last edge.
- Counters update on the same edge that samples the event.

## Structure
- Shared package `lb_pkg`: `LB_DW=32`, `LB_AW=16`, `LB_WIN_BITS=4`, control offset `LB_CTRL=0`, `LB_CTRL_COMMIT` bit index 0.
- One sub-module, `sat_counter`, with parameter width, inputs `inc` and `clr`, and the clear-plus-increment-gives-1 rule; it is instantiated twice.
- Shadow and active storage are flop arrays, not RAM, because `reg_flat` needs parallel read.

## Test plan
- Reset release, then write 0x12345678 to offset 3 (`addr_hi`=1, `lb_addr`=0x0013) -> shadow readback is 0x12345678, active readback is 0, `pending`=1, `write_cnt`=1.
- `apply` pulse -> `reg_flat[127:96]`=0x12345678, `update_stb` is one cycle high, `pending`=0; a second `apply` produces no `update_stb`.
- Write 0xA to offset 5 in the same cycle as `apply`, with offset 3 already dirty at 0x1 -> active[3]=1, active[5]=0, `pending`=1; the next `apply` gives active[5]=0xA.
- Write 0x1 to `lb_addr`=0x0010 with offset 7 dirty -> commit, `update_stb`; write to `lb_addr`=0x0023 -> no state change and `write_cnt` is unchanged.
- 0xFFFF+2 `collision` pulses -> `collision_cnt`=0xFFFF; then `clear_cnt` coincident with `collision` -> `collision_cnt`=1 and `collision_seen`=1.
- Assert `rst_n` low asynchronously between edges with pending writes -> all outputs are 0 immediately, with no `update_stb` after release.
